// File: rtl/sr_c_latch_pkg.sv
// Shared types and next-state decode for the synchronous gated SR latch bank.
package sr_c_latch_pkg;

    typedef enum logic [1:0] {
        ST_RESET   = 2'b00,
        ST_SET     = 2'b01,
        ST_ILLEGAL = 2'b10
    } cell_state_t;

    localparam cell_state_t CELL_RST_STATE = ST_RESET;

    // Next state of one cell from gate, set/reset requests and current state.
    // ILLEGAL never holds across an edge that does not re-assert it: it falls
    // back to RESET so the cell always leaves the S=R=1 condition deterministically.
    function automatic cell_state_t next_state(
        input logic        c,
        input logic        s,
        input logic        r,
        input cell_state_t state
    );
        cell_state_t nxt;
        nxt = state;
        if (c) begin
            case ({s, r})
                2'b10:   nxt = ST_SET;
                2'b01:   nxt = ST_RESET;
                2'b11:   nxt = ST_ILLEGAL;
                2'b00:   nxt = (state == ST_ILLEGAL) ? ST_RESET : state;
                default: nxt = CELL_RST_STATE;
            endcase
        end else begin
            nxt = (state == ST_ILLEGAL) ? ST_RESET : state;
        end
        // Unused encoding 2'b11 recovers to the reset state.
        if ((nxt != ST_RESET) && (nxt != ST_SET) && (nxt != ST_ILLEGAL)) begin
            nxt = CELL_RST_STATE;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/sr_c_latch_cell.sv
// One synchronous SR cell: state register plus Q/Qn/illegal decode from state.
module sr_c_latch_cell
    import sr_c_latch_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic c,
    input  logic s,
    input  logic r,
    output logic q,
    output logic qn,
    output logic illegal
);

    cell_state_t state_q;
    cell_state_t state_d;

    // Next-state decode of the gated SR command.
    always_comb begin
        state_d = next_state(c, s, r, state_q);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= CELL_RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output decode from the registered state only, so outputs never see S/R directly.
    always_comb begin
        q       = 1'b0;
        qn      = 1'b1;
        illegal = 1'b0;
        case (state_q)
            ST_SET: begin
                q       = 1'b1;
                qn      = 1'b0;
                illegal = 1'b0;
            end
            ST_ILLEGAL: begin
                q       = 1'b0;
                qn      = 1'b0;
                illegal = 1'b1;
            end
            ST_RESET: begin
                q       = 1'b0;
                qn      = 1'b1;
                illegal = 1'b0;
            end
            default: begin
                q       = 1'b0;
                qn      = 1'b1;
                illegal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/sr_c_latch.sv
// Bank of WIDTH independent synchronous SR cells sharing one gate enable.
module sr_c_latch
    import sr_c_latch_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             C,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qn,
    output logic [WIDTH-1:0] illegal
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_cell
            sr_c_latch_cell u_cell (
                .clk     (clk),
                .rst_n   (rst_n),
                .c       (C),
                .s       (S[gi]),
                .r       (R[gi]),
                .q       (Q[gi]),
                .qn      (Qn[gi]),
                .illegal (illegal[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_sr_c_latch.sv
// Self-checking bench for sr_c_latch (WIDTH=4): directed scenarios plus random stimulus.
module tb_sr_c_latch;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         C;
    logic [W-1:0] S;
    logic [W-1:0] R;
    logic [W-1:0] Q;
    logic [W-1:0] Qn;
    logic [W-1:0] illegal;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: latched value and illegal flag per bit, as vectors.
    logic [W-1:0] mq;
    logic [W-1:0] mil;

    sr_c_latch #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .C       (C),
        .S       (S),
        .R       (R),
        .Q       (Q),
        .Qn      (Qn),
        .illegal (illegal)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one input set, let one edge pass, advance the model, settle off-edge.
    task automatic step(input logic rn, input logic c, input logic [W-1:0] s, input logic [W-1:0] r);
        rst_n = rn;
        C     = c;
        S     = s;
        R     = r;
        @(posedge clk);
        if (!rn) begin
            mq  = '0;
            mil = '0;
        end else if (c) begin
            mq  = (s & ~r) | (mq & ~s & ~r);
            mil = s & r;
        end else begin
            mil = '0;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 4'hF, 4'h0);
        tests_run++;
        if ({Q, Qn, illegal} !== {4'h0, 4'hF, 4'h0}) begin
            tests_failed++;
            $display("FAIL reset_state: Q=%h Qn=%h ill=%h required Q=0 Qn=F ill=0", Q, Qn, illegal);
        end
        step(1'b1, 1'b1, 4'hF, 4'h0);
        tests_run++;
        if ({Q, Qn, illegal} !== {4'hF, 4'h0, 4'h0}) begin
            tests_failed++;
            $display("FAIL reset_release: Q=%h Qn=%h ill=%h required Q=F Qn=0 ill=0", Q, Qn, illegal);
        end
    endtask

    task automatic test_gate_closed();
        step(1'b0, 1'b0, 4'h0, 4'h0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 4'hF, 4'h0);
            tests_run++;
            if ({Q, Qn, illegal} !== {4'h0, 4'hF, 4'h0}) begin
                tests_failed++;
                $display("FAIL gate_closed[%0d]: Q=%h Qn=%h ill=%h required Q=0 Qn=F ill=0", i, Q, Qn, illegal);
            end
        end
        step(1'b1, 1'b1, 4'hF, 4'h0);
        tests_run++;
        if ({Q, Qn, illegal} !== {4'hF, 4'h0, 4'h0}) begin
            tests_failed++;
            $display("FAIL gate_open_set: Q=%h Qn=%h ill=%h required Q=F Qn=0 ill=0", Q, Qn, illegal);
        end
    endtask

    task automatic test_hold_then_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 4'h0, 4'hF);
            tests_run++;
            if ({Q, Qn, illegal} !== {4'hF, 4'h0, 4'h0}) begin
                tests_failed++;
                $display("FAIL hold_set[%0d]: Q=%h Qn=%h ill=%h required Q=F Qn=0 ill=0", i, Q, Qn, illegal);
            end
        end
        step(1'b1, 1'b1, 4'h0, 4'hF);
        tests_run++;
        if ({Q, Qn, illegal} !== {4'h0, 4'hF, 4'h0}) begin
            tests_failed++;
            $display("FAIL gated_reset: Q=%h Qn=%h ill=%h required Q=0 Qn=F ill=0", Q, Qn, illegal);
        end
        step(1'b1, 1'b0, 4'hF, 4'h0);
        tests_run++;
        if ({Q, Qn, illegal} !== {4'h0, 4'hF, 4'h0}) begin
            tests_failed++;
            $display("FAIL hold_reset: Q=%h Qn=%h ill=%h required Q=0 Qn=F ill=0", Q, Qn, illegal);
        end
    endtask

    task automatic test_illegal();
        step(1'b1, 1'b1, 4'hF, 4'hF);
        tests_run++;
        if ({Q, Qn, illegal} !== {4'h0, 4'h0, 4'hF}) begin
            tests_failed++;
            $display("FAIL illegal_enter: Q=%h Qn=%h ill=%h required Q=0 Qn=0 ill=F", Q, Qn, illegal);
        end
        step(1'b1, 1'b0, 4'h0, 4'h0);
        tests_run++;
        if ({Q, Qn, illegal} !== {4'h0, 4'hF, 4'h0}) begin
            tests_failed++;
            $display("FAIL illegal_exit_gate: Q=%h Qn=%h ill=%h required Q=0 Qn=F ill=0", Q, Qn, illegal);
        end
        step(1'b1, 1'b1, 4'hF, 4'hF);
        step(1'b1, 1'b1, 4'h0, 4'h0);
        tests_run++;
        if ({Q, Qn, illegal} !== {4'h0, 4'hF, 4'h0}) begin
            tests_failed++;
            $display("FAIL illegal_exit_idle: Q=%h Qn=%h ill=%h required Q=0 Qn=F ill=0", Q, Qn, illegal);
        end
    endtask

    task automatic test_illegal_to_set();
        step(1'b1, 1'b1, 4'hF, 4'hF);
        step(1'b1, 1'b1, 4'hF, 4'h0);
        tests_run++;
        if ({Q, Qn, illegal} !== {4'hF, 4'h0, 4'h0}) begin
            tests_failed++;
            $display("FAIL illegal_to_set: Q=%h Qn=%h ill=%h required Q=F Qn=0 ill=0", Q, Qn, illegal);
        end
    endtask

    task automatic test_mixed_bits();
        step(1'b0, 1'b0, 4'h0, 4'h0);
        step(1'b1, 1'b1, 4'b0011, 4'b0110);
        tests_run++;
        if ({Q, Qn, illegal} !== {4'b0001, 4'b1100, 4'b0010}) begin
            tests_failed++;
            $display("FAIL mixed_bits: Q=%h Qn=%h ill=%h required Q=1 Qn=C ill=2", Q, Qn, illegal);
        end
        step(1'b0, 1'b1, 4'b0011, 4'b0110);
        tests_run++;
        if ({Q, Qn, illegal} !== {4'h0, 4'hF, 4'h0}) begin
            tests_failed++;
            $display("FAIL mid_reset: Q=%h Qn=%h ill=%h required Q=0 Qn=F ill=0", Q, Qn, illegal);
        end
    endtask

    task automatic test_random();
        logic         rn;
        logic         c;
        logic [W-1:0] s;
        logic [W-1:0] r;
        for (int i = 0; i < 400; i++) begin
            rn = ($urandom_range(0, 19) != 0);
            c  = $urandom_range(0, 2) != 0;
            s  = W'($urandom);
            r  = W'($urandom);
            step(rn, c, s, r);
            tests_run++;
            if ({Q, Qn, illegal} !== {mq, ~(mq | mil), mil}) begin
                tests_failed++;
                $display("FAIL random[%0d]: Q=%h Qn=%h ill=%h required Q=%h Qn=%h ill=%h",
                         i, Q, Qn, illegal, mq, ~(mq | mil), mil);
            end
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        rst_n = 1'b0;
        C     = 1'b0;
        S     = '0;
        R     = '0;
        mq    = '0;
        mil   = '0;
        test_reset();
        test_gate_closed();
        test_hold_then_reset();
        test_illegal();
        test_illegal_to_set();
        test_mixed_bits();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
